// File: rtl/deadlock_aggregator_pkg.sv
// Shared definitions for the deadlock aggregator.
//   - dl_state_t  : aggregator FSM states (MONITOR / SUSPECT / DEADLOCK)
//   - DEF_*       : default parameter values used by the top level
//   - idx_width() : width of an index into an N-bit monitor vector
package deadlock_aggregator_pkg;

    typedef enum logic [1:0] {
        ST_MONITOR  = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } dl_state_t;

    localparam int DEF_NUM_MON     = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STALL_W     = 16;

    // Width of an index into an n-bit vector; never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deadlock_aggregator_dl_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   in_i  [N-1:0] : input vector
//   idx_o [W-1:0] : index of the lowest set bit of in_i, 0 when in_i is 0
module dl_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] in_i,
    output logic [W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/deadlock_aggregator.sv
// Deadlock aggregator: combines per-process block flags and declares a
// deadlock once every active (non-idle) process has been blocked, with an
// unchanged blocked set, for HOLD_CYCLES consecutive cycles.
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   mon_block        : per-process registered block flags
//   inst_idle        : per-process idle flags (idle processes are ignored)
//   clear            : single-cycle request to drop a latched deadlock
//   deadlock         : sticky deadlock flag
//   deadlock_pulse   : one-cycle strobe on deadlock declaration
//   deadlock_idx     : lowest-numbered process in the latched mask
//   deadlock_mask    : blocked set captured when suspicion began
//   stall_cycles     : saturating count of cycles with any active process blocked
//   fsm_state_o      : current FSM state (debug)
module deadlock_aggregator
    import deadlock_aggregator_pkg::*;
#(
    parameter int NUM_MON     = DEF_NUM_MON,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STALL_W     = DEF_STALL_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_MON-1:0]             mon_block,
    input  logic [NUM_MON-1:0]             inst_idle,
    input  logic                           clear,
    output logic                           deadlock,
    output logic                           deadlock_pulse,
    output logic [idx_width(NUM_MON)-1:0]  deadlock_idx,
    output logic [NUM_MON-1:0]             deadlock_mask,
    output logic [STALL_W-1:0]             stall_cycles,
    output logic [1:0]                     fsm_state_o
);

    localparam int IDX_W = idx_width(NUM_MON);
    localparam int HC_W  = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    logic [NUM_MON-1:0] active;
    logic [NUM_MON-1:0] cur_mask;
    logic               all_blocked;

    dl_state_t          state_q;
    logic [HC_W-1:0]    hold_cnt_q;
    logic [NUM_MON-1:0] snapshot_q;
    logic [NUM_MON-1:0] mask_q;
    logic [IDX_W-1:0]   idx_q;
    logic               deadlock_q;
    logic               pulse_q;
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W-1:0] stall_d;
    logic [IDX_W-1:0]   snap_idx;

    assign active      = ~inst_idle;
    assign cur_mask    = mon_block & active;
    // With no active process there is nothing that could be deadlocked.
    assign all_blocked = (cur_mask == active) && (active != '0);

    // Saturating increment while any active process is blocked.
    always_comb begin
        stall_d = stall_q;
        if ((cur_mask != '0) && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    dl_prio_enc #(
        .N (NUM_MON),
        .W (IDX_W)
    ) u_prio_enc (
        .in_i  (snapshot_q),
        .idx_o (snap_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_MONITOR;
            hold_cnt_q <= '0;
            snapshot_q <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
            deadlock_q <= 1'b0;
            pulse_q    <= 1'b0;
            stall_q    <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_MONITOR: begin
                    hold_cnt_q <= '0;
                    stall_q    <= stall_d;
                    // clear has priority over starting a new suspicion.
                    if (all_blocked && !clear) begin
                        state_q    <= ST_SUSPECT;
                        snapshot_q <= cur_mask;
                        hold_cnt_q <= HC_W'(1);
                    end
                end
                ST_SUSPECT: begin
                    stall_q <= stall_d;
                    // Any change to the blocked set restarts the full count.
                    if (clear || !all_blocked || (cur_mask != snapshot_q)) begin
                        state_q    <= ST_MONITOR;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= ST_DEADLOCK;
                        hold_cnt_q <= '0;
                        deadlock_q <= 1'b1;
                        pulse_q    <= 1'b1;
                        mask_q     <= snapshot_q;
                        idx_q      <= snap_idx;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HC_W'(1);
                    end
                end
                ST_DEADLOCK: begin
                    // Sticky: inputs are ignored, statistics frozen.
                    if (clear) begin
                        state_q    <= ST_MONITOR;
                        deadlock_q <= 1'b0;
                        mask_q     <= '0;
                        idx_q      <= '0;
                        stall_q    <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_MONITOR;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign deadlock       = deadlock_q;
    assign deadlock_pulse = pulse_q;
    assign deadlock_idx   = idx_q;
    assign deadlock_mask  = mask_q;
    assign stall_cycles   = stall_q;
    assign fsm_state_o    = state_q;

endmodule

// File: tb/tb_deadlock_aggregator.sv
module tb_deadlock_aggregator;

  localparam int NUM_MON = 4;
  localparam int HOLD    = 16;
  localparam int STALL_W = 16;
  localparam int STALL_MAX = 65535;

  logic               clock;
  logic               reset;
  logic [NUM_MON-1:0] mon_block;
  logic [NUM_MON-1:0] inst_idle;
  logic               clear;
  logic               deadlock;
  logic               deadlock_pulse;
  logic [1:0]         deadlock_idx;
  logic [NUM_MON-1:0] deadlock_mask;
  logic [STALL_W-1:0] stall_cycles;
  logic [1:0]         fsm_state_o;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  deadlock_aggregator #(
    .NUM_MON     (NUM_MON),
    .HOLD_CYCLES (HOLD),
    .STALL_W     (STALL_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mon_block      (mon_block),
    .inst_idle      (inst_idle),
    .clear          (clear),
    .deadlock       (deadlock),
    .deadlock_pulse (deadlock_pulse),
    .deadlock_idx   (deadlock_idx),
    .deadlock_mask  (deadlock_mask),
    .stall_cycles   (stall_cycles),
    .fsm_state_o    (fsm_state_o)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the length of the current run of "every active process blocked
  // with the same blocked set"; a run of HOLD cycles declares deadlock.
  int               run_len = 0;
  logic [3:0]       run_mask = '0;
  bit               m_dl = 0;
  bit               m_pulse = 0;
  logic [3:0]       m_mask = '0;
  int               m_idx = 0;
  int               m_stall = 0;

  function automatic int lowest_bit(input logic [3:0] v);
    for (int i = 0; i < NUM_MON; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock) begin : model
    logic [3:0] act;
    logic [3:0] cur;
    bit allb;
    act  = ~inst_idle;
    cur  = mon_block & act;
    allb = (cur == act) && (act != 4'b0000);
    m_pulse = 0;
    if (reset) begin
      m_dl = 0; m_mask = '0; m_idx = 0; m_stall = 0; run_len = 0; run_mask = '0;
    end else if (m_dl) begin
      if (clear) begin
        m_dl = 0; m_mask = '0; m_idx = 0; m_stall = 0;
      end
    end else begin
      if (cur != 4'b0000 && m_stall < STALL_MAX) m_stall++;
      if (clear || !allb || (run_len > 0 && cur != run_mask)) begin
        run_len = 0;
      end else begin
        if (run_len == 0) run_mask = cur;
        run_len++;
        if (run_len == HOLD) begin
          m_dl = 1; m_pulse = 1; m_mask = run_mask; m_idx = lowest_bit(run_mask);
          run_len = 0;
        end
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("deadlock",  32'(deadlock),       32'(m_dl));
      check("pulse",     32'(deadlock_pulse), 32'(m_pulse));
      check("mask",      32'(deadlock_mask),  32'(m_mask));
      check("idx",       32'(deadlock_idx),   32'(m_idx));
      check("stall",     32'(stall_cycles),   32'(m_stall));
      check("state",     32'(fsm_state_o),    m_dl ? 32'd2 : (run_len > 0 ? 32'd1 : 32'd0));
    end
  end

  // ---------------- driver ----------------
  // Inputs change just after a falling edge; returns at the next falling
  // edge, when outputs reflect the rising edge that sampled these inputs.
  task automatic drive(input logic [3:0] blk, input logic [3:0] idle, input logic clr);
    mon_block = blk;
    inst_idle = idle;
    clear     = clr;
    @(negedge clock);
  endtask

  task automatic drive_n(input int n, input logic [3:0] blk, input logic [3:0] idle);
    for (int i = 0; i < n; i++) drive(blk, idle, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mon_block = '0; inst_idle = '0; clear = 1'b0; reset = 1'b1;
    @(negedge clock);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    chk_en = 1;
    check("rst_deadlock", 32'(deadlock), 32'd0);
    check("rst_stall",    32'(stall_cycles), 32'd0);
    check("rst_state",    32'(fsm_state_o), 32'd0);

    // All four blocked for cycles 0..15: deadlock from cycle 16.
    drive_n(15, 4'b1111, 4'b0000);
    check("all_c15_deadlock", 32'(deadlock), 32'd0);
    drive(4'b1111, 4'b0000, 1'b0);
    check("all_c16_deadlock", 32'(deadlock), 32'd1);
    check("all_c16_pulse",    32'(deadlock_pulse), 32'd1);
    check("all_c16_mask",     32'(deadlock_mask), 32'hf);
    check("all_c16_idx",      32'(deadlock_idx), 32'd0);
    check("all_c16_stall",    32'(stall_cycles), 32'd16);
    // Sticky while the processes unblock; pulse gone.
    drive(4'b0000, 4'b0000, 1'b0);
    check("sticky_pulse",    32'(deadlock_pulse), 32'd0);
    drive_n(5, 4'b0000, 4'b0000);
    check("sticky_deadlock", 32'(deadlock), 32'd1);
    check("frozen_stall",    32'(stall_cycles), 32'd16);
    drive(4'b0000, 4'b0000, 1'b1);
    check("clr_deadlock", 32'(deadlock), 32'd0);
    check("clr_mask",     32'(deadlock_mask), 32'd0);
    check("clr_stall",    32'(stall_cycles), 32'd0);

    // Two idle processes, the other two blocked.
    drive_n(HOLD, 4'b1100, 4'b0011);
    check("part_deadlock", 32'(deadlock), 32'd1);
    check("part_mask",     32'(deadlock_mask), 32'hc);
    check("part_idx",      32'(deadlock_idx), 32'd2);
    drive(4'b0000, 4'b0000, 1'b1);

    // Everything idle: never suspicious, no stall counted.
    drive_n(20, 4'b1111, 4'b1111);
    check("idle_state", 32'(fsm_state_o), 32'd0);
    check("idle_stall", 32'(stall_cycles), 32'd0);

    // Break after 15 cycles restarts the full count.
    drive_n(15, 4'b1111, 4'b0000);
    drive(4'b0111, 4'b0000, 1'b0);
    drive_n(15, 4'b1111, 4'b0000);
    check("restart_c15", 32'(deadlock), 32'd0);
    drive(4'b1111, 4'b0000, 1'b0);
    check("restart_c16", 32'(deadlock), 32'd1);
    drive(4'b0000, 4'b0000, 1'b1);

    // Blocked set changes while still all-blocked (idle flag moves).
    drive_n(8, 4'b1111, 4'b0000);
    drive_n(HOLD, 4'b1110, 4'b0001);
    check("chg_deadlock", 32'(deadlock), 32'd0);
    drive(4'b1110, 4'b0001, 1'b0);
    check("chg_mask", 32'(deadlock_mask), 32'he);
    check("chg_idx",  32'(deadlock_idx), 32'd1);
    drive(4'b0000, 4'b0000, 1'b1);

    // clear in the same cycle all_blocked rises: stay in MONITOR.
    drive(4'b1111, 4'b0000, 1'b1);
    check("clr_wins_state", 32'(fsm_state_o), 32'd0);
    // Reset in the middle of suspicion (hold count 10).
    drive_n(10, 4'b1111, 4'b0000);
    check("suspect_state", 32'(fsm_state_o), 32'd1);
    reset = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0);
    check("rst_mid_state", 32'(fsm_state_o), 32'd0);
    check("rst_mid_pulse", 32'(deadlock_pulse), 32'd0);
    check("rst_mid_stall", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    drive_n(HOLD, 4'b1111, 4'b0000);
    check("post_rst_deadlock", 32'(deadlock), 32'd1);
    // Reset while deadlocked.
    reset = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0);
    check("rst_dl_deadlock", 32'(deadlock), 32'd0);
    check("rst_dl_mask",     32'(deadlock_mask), 32'd0);
    reset = 1'b0;

    // Long partial stall: counter saturates, never a deadlock.
    drive_n(70000, 4'b0001, 4'b0000);
    check("sat_stall",    32'(stall_cycles), 32'd65535);
    check("sat_deadlock", 32'(deadlock), 32'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
